tmds_lane_rx: RTL and testbench
===============================

// Module: tmds_lane_rx
// PURPOSE
// Receive side of one DVI/TMDS lane: deserialises a 1-bit-per-clock TMDS stream.
// Finds the 10-bit word boundary from control tokens and decodes each word to DE / 8-bit pixel data / 2-bit control.
// Used as the loopback checker for the DVI output path (paired with clk_bit) and as a building block for capture logic.
// PARAMETERS
// LOCK_COUNT     8     consecutive aligned control tokens required before declaring lock
// TIMEOUT_WORDS  1023  words allowed without a control token before lock is dropped (> active line length)
// PORTS
// clk        in   1  bit clock; one TMDS bit sampled per rising edge
// rst_n      in   1  asynchronous, active-low reset
// tmds_bit   in   1  serial TMDS bit, q[0] of each word first
// locked     out  1  word alignment established
// out_valid  out  1  one-cycle strobe: out_de/out_data/out_ctrl hold a new decoded word
// out_de     out  1  1 = data word, 0 = control token
// out_data   out  8  decoded pixel byte (valid when out_de=1, else 0)
// out_ctrl   out  2  decoded {C1,C0} (valid when out_de=0, else held at 0)
// BEHAVIOUR
// - Reset: locked=0, out_valid=0, out_de=0, out_data=0, out_ctrl=0; FSM=SEARCH; shift reg, phase, counters = 0.
// - Shift reg sr[9:0]: each clk, sr <= {tmds_bit, sr[9:1]}; after 10 bits sr == q[9:0].
// - Control tokens (q[9:0]): 1101010100->C=00, 0010101011->01, 0101010100->10, 1010101011->11.
// - phase counter 0..9 wraps 9->0; word strobe ws = (phase==9); sr evaluated on cycle after ws bit shifted in.
// - FSM SEARCH: evaluate sr every cycle; on control-token match, set phase so that this cycle is a boundary.
//   Then confirm_cnt=1 and go CONFIRM. The match cycle produces no output.
// - FSM CONFIRM: at each ws, token -> confirm_cnt+1; on reaching LOCK_COUNT go LOCKED and set locked=1.
//   Non-token -> confirm_cnt=0, back to SEARCH. The token that completes the count is not output.
// - FSM LOCKED: at each ws, register the decoded word; out_valid=1 on the following cycle only (1 pulse per 10 clks).
//   Latency: outputs update 1 clk after the 10th bit of the word is sampled.
// - Decode: d' = q[9] ? ~q[7:0] : q[7:0]; data[0]=d'[0].
//   For i=1..7: data[i] = q[8] ? d'[i]^d'[i-1] : ~(d'[i]^d'[i-1]).
// - Token word: out_de=0, out_ctrl=C, out_data=0. Any other word: out_de=1, out_data=decode, out_ctrl=0.
// - Timeout: word counter cleared by every token in LOCKED, incremented by every data word, saturating.
//   Reaching TIMEOUT_WORDS -> locked=0, FSM=SEARCH, counter=0.
//   The timing-out word is still output; its own token-clear has priority if it is a token.
// - out_valid=0 in SEARCH/CONFIRM; out_de/out_data/out_ctrl keep last values when out_valid=0.
// - rst_n asserted mid-word/mid-lock: immediate return to reset state; no partial word is output.
// TESTING
// - Reset: hold rst_n=0 with toggling tmds_bit -> all outputs 0, locked=0.
// - Lock: 3 garbage bits (101) then 8x token 1101010100 -> locked rises 1 clk after 80th token bit; no out_valid yet.
// - Decode: locked, send 0100000000 -> out_de=1, out_data=8'h00.
//   Then 1000000000 -> out_data=8'hFF. Then 0010101011 -> out_de=0, out_ctrl=2'b01. One out_valid per word, 10 clks apart.
// - Confirm break: 5 tokens then data word 0100000000 -> back to SEARCH, no out_valid.
//   Then 8 more tokens -> locked=1.
// - Timeout: locked, 1023 consecutive data words -> locked=0 after 1023rd word output.
//   Same run with a token at word 1000 -> stays locked.
// - Realignment: locked, slip stream by 1 bit and stop sending tokens -> lock lost at timeout.
//   Resume tokens -> relock at the new phase after 8 tokens.
// - Reset mid-lock: assert rst_n=0 mid-word -> locked=0, out_valid=0 same cycle (async); relock needs 8 tokens.

Source files
------------

// File: rtl/tmds_lane_rx.sv
// rtl/tmds_lane_rx.sv - TMDS single-lane receiver: deserialiser, word aligner and decoder
//
// Purpose:
//   Shifts in one TMDS bit per clock, finds the 10-bit word boundary from
//   control tokens, and decodes each aligned word into DE, an 8-bit pixel
//   byte or a 2-bit control value.
//
// Parameters:
//   LOCK_COUNT     consecutive aligned control tokens needed to declare lock
//   TIMEOUT_WORDS  words allowed without a control token before lock drops
//
// Ports:
//   clk        bit clock, one TMDS bit sampled per rising edge
//   rst_n      asynchronous active-low reset
//   tmds_bit   serial TMDS input, q[0] of each word first
//   locked     word alignment established
//   out_valid  one-cycle strobe when out_de/out_data/out_ctrl carry a new word
//   out_de     1 = data word, 0 = control token
//   out_data   decoded pixel byte (0 for control tokens)
//   out_ctrl   decoded {C1,C0} (0 for data words)

module tmds_lane_rx #(
  parameter int LOCK_COUNT    = 8,
  parameter int TIMEOUT_WORDS = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tmds_bit,
  output logic       locked,
  output logic       out_valid,
  output logic       out_de,
  output logic [7:0] out_data,
  output logic [1:0] out_ctrl
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT_WORDS + 1);

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t          state;
  logic [9:0]      sr;
  logic [3:0]      phase;
  logic [CW-1:0]   confirm_cnt;
  logic [TW-1:0]   word_cnt;

  logic            is_token;
  logic [1:0]      tok_ctrl;
  logic [7:0]      d_prime;
  logic [7:0]      dec_data;
  logic            ws;

  // sr holds a complete word on the cycle after its 10th bit was shifted in;
  // phase 9 marks that cycle once alignment has been chosen.
  assign ws = (phase == 4'd9);

  always_comb begin
    is_token = 1'b1;
    tok_ctrl = 2'b00;
    case (sr)
      TOKEN_C00: tok_ctrl = 2'b00;
      TOKEN_C01: tok_ctrl = 2'b01;
      TOKEN_C10: tok_ctrl = 2'b10;
      TOKEN_C11: tok_ctrl = 2'b11;
      default:   is_token = 1'b0;
    endcase
  end

  // TMDS data decode: undo the optional inversion (q[9]) then the
  // XOR/XNOR transition chain selected by q[8].
  always_comb begin
    d_prime     = sr[9] ? ~sr[7:0] : sr[7:0];
    dec_data    = 8'h00;
    dec_data[0] = d_prime[0];
    for (int i = 1; i < 8; i++) begin
      dec_data[i] = sr[8] ? (d_prime[i] ^ d_prime[i-1])
                          : ~(d_prime[i] ^ d_prime[i-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SEARCH;
      sr          <= 10'd0;
      phase       <= 4'd0;
      confirm_cnt <= '0;
      word_cnt    <= '0;
      locked      <= 1'b0;
      out_valid   <= 1'b0;
      out_de      <= 1'b0;
      out_data    <= 8'h00;
      out_ctrl    <= 2'b00;
    end else begin
      sr        <= {tmds_bit, sr[9:1]};
      out_valid <= 1'b0;
      phase     <= ws ? 4'd0 : phase + 4'd1;

      case (state)
        ST_SEARCH: begin
          // Any token seen at any bit offset defines a candidate boundary:
          // treat this cycle as phase 9 so the next word ends 10 clocks on.
          if (is_token) begin
            phase       <= 4'd0;
            confirm_cnt <= CW'(1);
            state       <= ST_CONFIRM;
          end
        end

        ST_CONFIRM: begin
          if (ws) begin
            if (is_token) begin
              if (confirm_cnt == CW'(LOCK_COUNT - 1)) begin
                state       <= ST_LOCKED;
                locked      <= 1'b1;
                confirm_cnt <= '0;
                word_cnt    <= '0;
              end else begin
                confirm_cnt <= confirm_cnt + CW'(1);
              end
            end else begin
              confirm_cnt <= '0;
              state       <= ST_SEARCH;
            end
          end
        end

        ST_LOCKED: begin
          if (ws) begin
            out_valid <= 1'b1;
            out_de    <= ~is_token;
            out_data  <= is_token ? 8'h00 : dec_data;
            out_ctrl  <= is_token ? tok_ctrl : 2'b00;
            if (is_token) begin
              word_cnt <= '0;
            end else if (word_cnt >= TW'(TIMEOUT_WORDS - 1)) begin
              // This word reaches the timeout: it is still output above,
              // but alignment is abandoned.
              word_cnt <= '0;
              locked   <= 1'b0;
              state    <= ST_SEARCH;
            end else begin
              word_cnt <= word_cnt + TW'(1);
            end
          end
        end

        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_lane_rx.sv
// tb/tb_tmds_lane_rx.sv - directed testbench for tmds_lane_rx

module tb_tmds_lane_rx;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] DAT00 = 10'b0100000000;
  localparam logic [9:0] DATFF = 10'b1000000000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tmds_bit;
  logic       locked;
  logic       out_valid;
  logic       out_de;
  logic [7:0] out_data;
  logic [1:0] out_ctrl;

  int         n_checks;
  int         n_fail;
  int         vcnt;
  int         bitcnt;
  int         last_vbit;
  int         vgap;
  int         last_pos;
  int         drop_bit;
  logic       last_de;
  logic [7:0] last_data;
  logic [1:0] last_ctrl;
  logic       locked_b0;
  logic       prev_locked;

  tmds_lane_rx #(
    .LOCK_COUNT   (8),
    .TIMEOUT_WORDS(1023)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tmds_bit (tmds_bit),
    .locked   (locked),
    .out_valid(out_valid),
    .out_de   (out_de),
    .out_data (out_data),
    .out_ctrl (out_ctrl)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b, input int pos);
    tmds_bit = b;
    @(posedge clk);
    #1;
    bitcnt++;
    if (out_valid) begin
      vcnt++;
      vgap      = bitcnt - last_vbit;
      last_vbit = bitcnt;
      last_de   = out_de;
      last_data = out_data;
      last_ctrl = out_ctrl;
      last_pos  = pos;
    end
    if (prev_locked && !locked) drop_bit = bitcnt;
    prev_locked = locked;
  endtask

  task automatic send_word(input logic [9:0] q);
    for (int i = 0; i < 10; i++) begin
      send_bit(q[i], i);
      if (i == 0) locked_b0 = locked;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) send_bit(1'b0, -1);
    rst_n = 1'b1;
  endtask

  task automatic do_lock();
    do_reset();
    repeat (8) send_word(TOK00);
  endtask

  task automatic test_reset();
    int v0;
    rst_n = 1'b0;
    v0 = vcnt;
    for (int i = 0; i < 20; i++) send_bit(i[0], -1);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_de !== 1'b0) begin n_fail++; $display("FAIL reset_out_de: got %b expected 0", out_de); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    n_checks++; if (out_ctrl !== 2'b00) begin n_fail++; $display("FAIL reset_out_ctrl: got %b expected 00", out_ctrl); end
    n_checks++; if (vcnt !== v0) begin n_fail++; $display("FAIL reset_no_valid: got %0d strobes expected 0", vcnt - v0); end
  endtask

  task automatic test_lock();
    int v0;
    rst_n = 1'b1;
    v0 = vcnt;
    send_bit(1'b1, -1);
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    repeat (8) send_word(TOK00);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_not_early: got %b expected 0", locked); end
    n_checks++; if (vcnt !== v0) begin n_fail++; $display("FAIL lock_no_valid: got %0d strobes expected 0", vcnt - v0); end
  endtask

  task automatic test_decode();
    int v0;
    v0 = vcnt;
    send_word(DAT00);
    n_checks++; if (locked_b0 !== 1'b1) begin n_fail++; $display("FAIL lock_rise: got %b expected 1", locked_b0); end
    n_checks++; if (vcnt !== v0) begin n_fail++; $display("FAIL lock_token_not_output: got %0d strobes expected 0", vcnt - v0); end
    send_word(DATFF);
    n_checks++; if (vcnt !== v0 + 1) begin n_fail++; $display("FAIL dec0_count: got %0d expected %0d", vcnt - v0, 1); end
    n_checks++; if (last_pos !== 0) begin n_fail++; $display("FAIL dec0_latency: got bit %0d expected 0", last_pos); end
    n_checks++; if (last_de !== 1'b1) begin n_fail++; $display("FAIL dec0_de: got %b expected 1", last_de); end
    n_checks++; if (last_data !== 8'h00) begin n_fail++; $display("FAIL dec0_data: got %h expected 00", last_data); end
    n_checks++; if (last_ctrl !== 2'b00) begin n_fail++; $display("FAIL dec0_ctrl: got %b expected 00", last_ctrl); end
    send_word(TOK01);
    n_checks++; if (vcnt !== v0 + 2) begin n_fail++; $display("FAIL decff_count: got %0d expected %0d", vcnt - v0, 2); end
    n_checks++; if (last_data !== 8'hFF) begin n_fail++; $display("FAIL decff_data: got %h expected ff", last_data); end
    n_checks++; if (last_de !== 1'b1) begin n_fail++; $display("FAIL decff_de: got %b expected 1", last_de); end
    n_checks++; if (vgap !== 10) begin n_fail++; $display("FAIL decff_spacing: got %0d expected 10", vgap); end
    send_word(TOK00);
    n_checks++; if (vcnt !== v0 + 3) begin n_fail++; $display("FAIL tok_count: got %0d expected %0d", vcnt - v0, 3); end
    n_checks++; if (last_de !== 1'b0) begin n_fail++; $display("FAIL tok_de: got %b expected 0", last_de); end
    n_checks++; if (last_ctrl !== 2'b01) begin n_fail++; $display("FAIL tok_ctrl: got %b expected 01", last_ctrl); end
    n_checks++; if (last_data !== 8'h00) begin n_fail++; $display("FAIL tok_data: got %h expected 00", last_data); end
    n_checks++; if (vgap !== 10) begin n_fail++; $display("FAIL tok_spacing: got %0d expected 10", vgap); end
  endtask

  task automatic test_confirm_break();
    int v0;
    do_reset();
    v0 = vcnt;
    repeat (5) send_word(TOK00);
    send_word(DAT00);
    send_word(DAT00);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL break_locked: got %b expected 0", locked); end
    n_checks++; if (vcnt !== v0) begin n_fail++; $display("FAIL break_no_valid: got %0d strobes expected 0", vcnt - v0); end
    repeat (8) send_word(TOK00);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL break_relock_early: got %b expected 0", locked); end
    send_word(DAT00);
    n_checks++; if (locked_b0 !== 1'b1) begin n_fail++; $display("FAIL break_relock: got %b expected 1", locked_b0); end
    n_checks++; if (vcnt !== v0) begin n_fail++; $display("FAIL break_relock_valid: got %0d strobes expected 0", vcnt - v0); end
  endtask

  task automatic test_timeout();
    int v0;
    do_lock();
    v0 = vcnt;
    repeat (1023) send_word(DAT00);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL timeout_before: got %b expected 1", locked); end
    send_word(DAT00);
    n_checks++; if (locked_b0 !== 1'b0) begin n_fail++; $display("FAIL timeout_drop: got %b expected 0", locked_b0); end
    n_checks++; if (vcnt !== v0 + 1023) begin n_fail++; $display("FAIL timeout_count: got %0d expected 1023", vcnt - v0); end
    n_checks++; if (last_pos !== 0 || last_de !== 1'b1) begin n_fail++; $display("FAIL timeout_last_word: got pos %0d de %b expected pos 0 de 1", last_pos, last_de); end
  endtask

  task automatic test_timeout_token();
    int v0;
    do_lock();
    v0 = vcnt;
    repeat (999) send_word(DAT00);
    send_word(TOK00);
    repeat (23) send_word(DAT00);
    send_word(DAT00);
    n_checks++; if (locked_b0 !== 1'b1) begin n_fail++; $display("FAIL timeout_token_hold: got %b expected 1", locked_b0); end
    n_checks++; if (vcnt !== v0 + 1023) begin n_fail++; $display("FAIL timeout_token_count: got %0d expected 1023", vcnt - v0); end
  endtask

  task automatic test_realign();
    int b0;
    do_lock();
    b0 = bitcnt;
    drop_bit = -1;
    repeat (3) send_word(DAT00);
    send_bit(1'b0, -1);
    for (int k = 0; k < 1100 && locked; k++) send_word(DAT00);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL realign_drop: got %b expected 0", locked); end
    n_checks++; if (drop_bit - b0 !== 10231) begin n_fail++; $display("FAIL realign_drop_time: got %0d bits expected 10231", drop_bit - b0); end
    repeat (8) send_word(TOK00);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL realign_early: got %b expected 0", locked); end
    send_word(DAT00);
    n_checks++; if (locked_b0 !== 1'b1) begin n_fail++; $display("FAIL realign_relock: got %b expected 1", locked_b0); end
    send_word(DATFF);
    n_checks++; if (last_pos !== 0 || last_de !== 1'b1 || last_data !== 8'h00) begin
      n_fail++; $display("FAIL realign_decode: got pos %0d de %b data %h expected pos 0 de 1 data 00", last_pos, last_de, last_data);
    end
  endtask

  task automatic test_reset_mid_lock();
    int v0;
    do_lock();
    send_word(DAT00);
    send_bit(1'b0, 0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_valid: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midreset_locked: got %b expected 0", locked); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_de !== 1'b0) begin n_fail++; $display("FAIL midreset_de: got %b expected 0", out_de); end
    repeat (2) send_bit(1'b1, -1);
    rst_n = 1'b1;
    v0 = vcnt;
    repeat (7) send_word(TOK00);
    send_word(TOK00);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midreset_early: got %b expected 0", locked); end
    send_word(DAT00);
    n_checks++; if (locked_b0 !== 1'b1) begin n_fail++; $display("FAIL midreset_relock: got %b expected 1", locked_b0); end
    n_checks++; if (vcnt !== v0) begin n_fail++; $display("FAIL midreset_no_valid: got %0d strobes expected 0", vcnt - v0); end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    vcnt        = 0;
    bitcnt      = 0;
    last_vbit   = 0;
    vgap        = 0;
    last_pos    = -1;
    drop_bit    = -1;
    last_de     = 1'b0;
    last_data   = 8'h00;
    last_ctrl   = 2'b00;
    locked_b0   = 1'b0;
    prev_locked = 1'b0;
    rst_n       = 1'b0;
    tmds_bit    = 1'b0;
    #1;

    test_reset();
    test_lock();
    test_decode();
    test_confirm_break();
    test_timeout();
    test_timeout_token();
    test_realign();
    test_reset_mid_lock();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
